// File: rtl/vga_timing_rx.sv
// -----------------------------------------------------------------------------
// vga_timing_rx
//   Receive end of a VGA timing link. Samples hsync/vsync/valid/RGB444,
//   recovers active-pixel coordinates, measures line and frame geometry and
//   reports lock against the expected geometry.
//
//   Optional feature macro: VGA_RX_CHECKSUM_EN
//     defined   : frame_sum carries a 16-bit wrapping sum of the pixels of the
//                 last completed frame.
//     undefined : frame_sum is tied to 0 and no accumulator is built.
//
// Ports
//   vga_clk       in   pixel clock
//   rst           in   synchronous reset, active-high
//   vga_hsync     in   line sync, active-low
//   vga_vsync     in   frame sync, active-low
//   vga_valid     in   active-pixel qualifier
//   vga_data      in   RGB444 pixel
//   pix_data      out  registered pixel, 0 outside active video
//   pix_valid     out  registered vga_valid
//   pixel_x       out  column within the active line, 10'h3FF when not valid
//   pixel_y       out  active-line index within the frame, 10'h3FF when not valid
//   line_start    out  one-cycle pulse per hsync falling edge
//   frame_start   out  one-cycle pulse per vsync falling edge
//   h_total_meas  out  clocks in the last completed line
//   v_total_meas  out  lines in the last completed frame
//   locked        out  geometry matches the parameters
//   err           out  one-cycle pulse on geometry mismatch or line timeout
//   frame_sum     out  per-frame pixel checksum (checksum build only)
//
// Every output is registered two clocks after the input event that causes it.
// -----------------------------------------------------------------------------
module vga_timing_rx #(
   parameter int H_TOTAL     = 800,
   parameter int V_TOTAL     = 525,
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter int LOCK_FRAMES = 2
) (
   input  logic        vga_clk,
   input  logic        rst,
   input  logic        vga_hsync,
   input  logic        vga_vsync,
   input  logic        vga_valid,
   input  logic [11:0] vga_data,
   output logic [11:0] pix_data,
   output logic        pix_valid,
   output logic [9:0]  pixel_x,
   output logic [9:0]  pixel_y,
   output logic        line_start,
   output logic        frame_start,
   output logic [10:0] h_total_meas,
   output logic [9:0]  v_total_meas,
   output logic        locked,
   output logic        err,
   output logic [15:0] frame_sum
);

   localparam logic [10:0] H_TOTAL_C  = 11'(H_TOTAL);
   localparam logic [10:0] H_ACTIVE_C = 11'(H_ACTIVE);
   localparam logic [9:0]  V_TOTAL_C  = 10'(V_TOTAL);
   localparam logic [9:0]  V_ACTIVE_C = 10'(V_ACTIVE);
   localparam logic [10:0] TIMEOUT_C  = 11'(2 * H_TOTAL - 1);
   localparam logic [7:0]  LOCK_C     = 8'(LOCK_FRAMES);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_MEASURE = 2'd1,
      S_LOCKED  = 2'd2
   } state_t;

   // Increment that sticks at the top of the 11-bit range.
   function automatic logic [10:0] sat_inc11(input logic [10:0] v);
      return (v == 11'h7FF) ? v : v + 11'd1;
   endfunction

   // Stage A: raw input registers
   logic        hs_a_q, hs_a_d;
   logic        vs_a_q, vs_a_d;
   logic        vld_a_q, vld_a_d;
   logic [11:0] dat_a_q, dat_a_d;
   // Stage B: previous stage-A sync levels for edge detection
   logic        hs_b_q, hs_b_d;
   logic        vs_b_q, vs_b_d;

   // Geometry measurement state
   logic [10:0] h_cnt_q, h_cnt_d;
   logic [9:0]  v_cnt_q, v_cnt_d;
   logic [10:0] act_cnt_q, act_cnt_d;
   logic [9:0]  x_cnt_q, x_cnt_d;
   logic [9:0]  y_cnt_q, y_cnt_d;
   logic        line_bad_acc_q, line_bad_acc_d;
   logic [7:0]  good_cnt_q, good_cnt_d;
   state_t      state_q, state_d;

   // Output registers
   logic [11:0] pix_data_q, pix_data_d;
   logic        pix_valid_q, pix_valid_d;
   logic [9:0]  pixel_x_q, pixel_x_d;
   logic [9:0]  pixel_y_q, pixel_y_d;
   logic        line_start_q, line_start_d;
   logic        frame_start_q, frame_start_d;
   logic [10:0] h_total_meas_q, h_total_meas_d;
   logic [9:0]  v_total_meas_q, v_total_meas_d;
   logic        locked_q, locked_d;
   logic        err_q, err_d;

   // Decoded events and per-line/per-frame judgements
   logic        hs_fall, vs_fall, vld_end;
   logic [10:0] h_meas_new, line_width;
   logic [9:0]  v_meas_new, act_lines;
   logic [9:0]  x_eff, y_eff;
   logic        line_bad, frame_bad, timeout, drop;

   // Stage A/B -> events and datapath
   always_comb begin
      hs_a_d  = vga_hsync;
      vs_a_d  = vga_vsync;
      vld_a_d = vga_valid;
      dat_a_d = vga_data;
      hs_b_d  = hs_a_q;
      vs_b_d  = vs_a_q;

      hs_fall = ~hs_a_q & hs_b_q;
      vs_fall = ~vs_a_q & vs_b_q;
      // pix_valid_q holds the previous stage-A valid, so this marks the first
      // blank cycle after an active run.
      vld_end = ~vld_a_q & pix_valid_q;

      // The cycle on which a fall is seen closes the old line, so its count
      // and its pixel (if any) belong to the line being judged.
      h_meas_new = sat_inc11(h_cnt_q);
      line_width = vld_a_q ? sat_inc11(act_cnt_q) : act_cnt_q;
      line_bad   = (h_meas_new != H_TOTAL_C) ||
                   ((line_width != 11'd0) && (line_width != H_ACTIVE_C));

      v_meas_new = v_cnt_q + 10'd1;
      act_lines  = y_cnt_q + {9'd0, vld_end};

      h_cnt_d        = hs_fall ? 11'd0 : sat_inc11(h_cnt_q);
      act_cnt_d      = hs_fall ? 11'd0 : line_width;
      h_total_meas_d = hs_fall ? h_meas_new : h_total_meas_q;

      // vsync wins when both syncs fall on the same cycle.
      if (vs_fall) begin
         v_cnt_d = 10'd0;
      end else if (hs_fall) begin
         v_cnt_d = v_cnt_q + 10'd1;
      end else begin
         v_cnt_d = v_cnt_q;
      end
      v_total_meas_d = vs_fall ? v_meas_new : v_total_meas_q;

      timeout = (h_cnt_q == TIMEOUT_C) && !hs_fall;

      // Pixel coordinates: the cycle carrying a fall already belongs to the
      // new line/frame for addressing purposes.
      x_eff   = hs_fall ? 10'd0 : x_cnt_q;
      y_eff   = vs_fall ? 10'd0 : y_cnt_q;
      x_cnt_d = vld_a_q ? x_eff + 10'd1 : x_eff;
      if (vs_fall) begin
         y_cnt_d = 10'd0;
      end else if (vld_end) begin
         y_cnt_d = y_cnt_q + 10'd1;
      end else begin
         y_cnt_d = y_cnt_q;
      end

      pix_valid_d   = vld_a_q;
      pix_data_d    = vld_a_q ? dat_a_q : 12'h000;
      pixel_x_d     = vld_a_q ? x_eff : 10'h3FF;
      pixel_y_d     = vld_a_q ? y_eff : 10'h3FF;
      line_start_d  = hs_fall;
      frame_start_d = vs_fall;
   end

   // Lock FSM: next state and flags
   always_comb begin
      state_d    = state_q;
      good_cnt_d = good_cnt_q;
      err_d      = 1'b0;
      drop       = 1'b0;

      frame_bad = (v_meas_new != V_TOTAL_C) || line_bad_acc_q ||
                  (hs_fall && line_bad) || (act_lines != V_ACTIVE_C);

      unique case (state_q)
         S_IDLE: begin
            // The frame in progress at reset is never judged.
            if (vs_fall) begin
               state_d    = S_MEASURE;
               good_cnt_d = 8'd0;
            end
         end
         S_MEASURE: begin
            if (vs_fall) begin
               if (frame_bad) begin
                  good_cnt_d = 8'd0;
                  err_d      = 1'b1;
               end else begin
                  good_cnt_d = good_cnt_q + 8'd1;
                  if (good_cnt_q + 8'd1 >= LOCK_C) begin
                     state_d = S_LOCKED;
                  end
               end
            end
         end
         S_LOCKED: begin
            if ((hs_fall && line_bad) || (vs_fall && frame_bad)) begin
               state_d    = S_MEASURE;
               good_cnt_d = 8'd0;
               err_d      = 1'b1;
               drop       = 1'b1;
            end
         end
         default: begin
            state_d    = S_IDLE;
            good_cnt_d = 8'd0;
         end
      endcase

      // h_cnt passes the timeout value only once before saturating, so a
      // held-high hsync produces a single err pulse.
      if (timeout) begin
         state_d    = S_IDLE;
         good_cnt_d = 8'd0;
         err_d      = 1'b1;
      end

      // A bad line that knocks us out of lock has already been reported;
      // the remainder of that frame is judged afresh.
      if (vs_fall || drop) begin
         line_bad_acc_d = 1'b0;
      end else begin
         line_bad_acc_d = line_bad_acc_q | (hs_fall & line_bad);
      end

      locked_d = (state_d == S_LOCKED);
   end

   // Registers: stage A/B, counters, outputs
   always_ff @(posedge vga_clk) begin
      if (rst) begin
         hs_a_q         <= 1'b1;
         vs_a_q         <= 1'b1;
         hs_b_q         <= 1'b1;
         vs_b_q         <= 1'b1;
         vld_a_q        <= 1'b0;
         dat_a_q        <= 12'h000;
         h_cnt_q        <= 11'd0;
         v_cnt_q        <= 10'd0;
         act_cnt_q      <= 11'd0;
         x_cnt_q        <= 10'd0;
         y_cnt_q        <= 10'd0;
         line_bad_acc_q <= 1'b0;
         good_cnt_q     <= 8'd0;
         state_q        <= S_IDLE;
         pix_data_q     <= 12'h000;
         pix_valid_q    <= 1'b0;
         pixel_x_q      <= 10'h3FF;
         pixel_y_q      <= 10'h3FF;
         line_start_q   <= 1'b0;
         frame_start_q  <= 1'b0;
         h_total_meas_q <= 11'd0;
         v_total_meas_q <= 10'd0;
         locked_q       <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         hs_a_q         <= hs_a_d;
         vs_a_q         <= vs_a_d;
         hs_b_q         <= hs_b_d;
         vs_b_q         <= vs_b_d;
         vld_a_q        <= vld_a_d;
         dat_a_q        <= dat_a_d;
         h_cnt_q        <= h_cnt_d;
         v_cnt_q        <= v_cnt_d;
         act_cnt_q      <= act_cnt_d;
         x_cnt_q        <= x_cnt_d;
         y_cnt_q        <= y_cnt_d;
         line_bad_acc_q <= line_bad_acc_d;
         good_cnt_q     <= good_cnt_d;
         state_q        <= state_d;
         pix_data_q     <= pix_data_d;
         pix_valid_q    <= pix_valid_d;
         pixel_x_q      <= pixel_x_d;
         pixel_y_q      <= pixel_y_d;
         line_start_q   <= line_start_d;
         frame_start_q  <= frame_start_d;
         h_total_meas_q <= h_total_meas_d;
         v_total_meas_q <= v_total_meas_d;
         locked_q       <= locked_d;
         err_q          <= err_d;
      end
   end

`ifdef VGA_RX_CHECKSUM_EN
   logic [15:0] sum_q, sum_d;
   logic [15:0] frame_sum_q, frame_sum_d;

   // The pixel on the vsync-fall cycle opens the new frame's sum.
   always_comb begin
      if (vs_fall) begin
         sum_d       = {4'h0, pix_data_d};
         frame_sum_d = sum_q;
      end else begin
         sum_d       = sum_q + {4'h0, pix_data_d};
         frame_sum_d = frame_sum_q;
      end
   end

   always_ff @(posedge vga_clk) begin
      if (rst) begin
         sum_q       <= 16'h0000;
         frame_sum_q <= 16'h0000;
      end else begin
         sum_q       <= sum_d;
         frame_sum_q <= frame_sum_d;
      end
   end

   assign frame_sum = frame_sum_q;
`else
   assign frame_sum = 16'h0000;
`endif

   assign pix_data     = pix_data_q;
   assign pix_valid    = pix_valid_q;
   assign pixel_x      = pixel_x_q;
   assign pixel_y      = pixel_y_q;
   assign line_start   = line_start_q;
   assign frame_start  = frame_start_q;
   assign h_total_meas = h_total_meas_q;
   assign v_total_meas = v_total_meas_q;
   assign locked       = locked_q;
   assign err          = err_q;

endmodule
